// File: rtl/match_link_ctrl.sv
// match_link_ctrl: matchmaking handshake between two game boards.
// Advertises readiness on rdy_out, qualifies the opponent's ready line
// (synchronized, then held for HOLD_CYC samples), retries on timeout,
// and reports link-up / match success / match failure to the status FSM.
module match_link_ctrl #(
  parameter int TIMEOUT_CYC = 100,
  parameter int MAX_RETRY   = 3,
  parameter int HOLD_CYC    = 4
) (
  input  logic       clk_100,
  input  logic       rst,
  input  logic       req_match,
  input  logic       cancel,
  input  logic       peer_rdy_in,
  output logic       rdy_out,
  output logic       link_up,
  output logic       match_ok,
  output logic       match_fail,
  output logic [1:0] retry_cnt,
  output logic [2:0] link_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADVERTISE = 3'd1,
    CONFIRM   = 3'd2,
    LINKED    = 3'd3,
    BACKOFF   = 3'd4,
    FAIL      = 3'd5
  } state_t;

  // The timer serves both the advertise window and the backoff window.
  localparam int TW = $clog2(TIMEOUT_CYC + 2 * HOLD_CYC + 1);
  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] BACKOFF_LAST = TW'(2 * HOLD_CYC - 1);
  localparam logic [HW-1:0] HOLD_MAX     = HW'(HOLD_CYC);
  localparam logic [1:0]    RETRY_LAST   = 2'(MAX_RETRY - 1);

  state_t        state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [HW-1:0] hold_reg, hold_next, hold_inc;
  logic [1:0]    retry_reg, retry_next;
  logic          sync1_reg, sync2_reg;
  logic          peer_s;
  logic          qual_level;
  logic          qualified;
  logic          rdy_reg, link_up_reg, match_ok_reg, match_fail_reg;

  assign peer_s = sync2_reg;

  // Two-flop synchronizer for the opponent's asynchronous ready line.
  always_ff @(posedge clk_100 or negedge rst) begin
    if (!rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= peer_rdy_in;
      sync2_reg <= sync1_reg;
    end
  end

  // Next-state logic: hold qualification, attempt timer, retry count, cancel override.
  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    retry_next = retry_reg;
    hold_next  = '0;
    // In LINKED we watch for the peer going low; elsewhere for it going high.
    qual_level = (state_reg != LINKED);
    if (peer_s == qual_level) begin
      hold_inc = (hold_reg == HOLD_MAX) ? HOLD_MAX : hold_reg + HW'(1);
    end else begin
      hold_inc = '0;
    end
    qualified = (hold_inc == HOLD_MAX);

    case (state_reg)
      IDLE: begin
        if (req_match && !cancel) begin
          state_next = ADVERTISE;
          timer_next = '0;
          retry_next = '0;
        end
      end
      ADVERTISE: begin
        timer_next = timer_reg + TW'(1);
        hold_next  = hold_inc;
        // Qualification wins over a timeout landing in the same cycle.
        if (qualified) begin
          state_next = CONFIRM;
        end else if (timer_reg == TIMEOUT_LAST) begin
          if (retry_reg == RETRY_LAST) begin
            state_next = FAIL;
          end else begin
            state_next = BACKOFF;
            retry_next = retry_reg + 2'd1;
            timer_next = '0;
          end
        end
      end
      BACKOFF: begin
        timer_next = timer_reg + TW'(1);
        if (timer_reg == BACKOFF_LAST) begin
          state_next = ADVERTISE;
          timer_next = '0;
        end
      end
      CONFIRM: begin
        // Timer is frozen here so a bounce back to ADVERTISE resumes the same window.
        hold_next = hold_inc;
        if (!peer_s) begin
          state_next = ADVERTISE;
        end else if (qualified) begin
          state_next = LINKED;
        end
      end
      LINKED: begin
        hold_next = hold_inc;
        if (qualified) begin
          state_next = FAIL;
        end
      end
      FAIL: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (cancel && (state_reg != IDLE)) begin
      state_next = IDLE;
    end
    // Every state change restarts qualification from scratch.
    if (state_next != state_reg) begin
      hold_next = '0;
    end
  end

  // State, counters and registered outputs derived from the upcoming state.
  always_ff @(posedge clk_100 or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      timer_reg      <= '0;
      hold_reg       <= '0;
      retry_reg      <= '0;
      rdy_reg        <= 1'b0;
      link_up_reg    <= 1'b0;
      match_ok_reg   <= 1'b0;
      match_fail_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      timer_reg      <= timer_next;
      hold_reg       <= hold_next;
      retry_reg      <= retry_next;
      rdy_reg        <= (state_next == ADVERTISE) || (state_next == CONFIRM) ||
                        (state_next == LINKED);
      link_up_reg    <= (state_next == LINKED);
      match_ok_reg   <= (state_next == LINKED) && (state_reg != LINKED);
      match_fail_reg <= (state_next == FAIL);
    end
  end

  assign rdy_out    = rdy_reg;
  assign link_up    = link_up_reg;
  assign match_ok   = match_ok_reg;
  assign match_fail = match_fail_reg;
  assign retry_cnt  = retry_reg;
  assign link_state = state_reg;

endmodule

// File: tb/tb_match_link_ctrl.sv
// Testbench for match_link_ctrl: directed scenarios plus random traffic,
// with a behavioural model feeding a scoreboard checked by a monitor.
module tb_match_link_ctrl;

  localparam int T = 100;
  localparam int MAXR = 3;
  localparam int H = 4;

  localparam int P_IDLE = 0, P_ADV = 1, P_CONF = 2, P_LINK = 3, P_BO = 4, P_FAIL = 5;

  logic       clk_100 = 1'b0;
  logic       rst = 1'b0;
  logic       req_match = 1'b0;
  logic       cancel = 1'b0;
  logic       peer_rdy_in = 1'b0;
  logic       rdy_out, link_up, match_ok, match_fail;
  logic [1:0] retry_cnt;
  logic [2:0] link_state;

  match_link_ctrl #(.TIMEOUT_CYC(T), .MAX_RETRY(MAXR), .HOLD_CYC(H)) dut (
    .clk_100(clk_100), .rst(rst), .req_match(req_match), .cancel(cancel),
    .peer_rdy_in(peer_rdy_in), .rdy_out(rdy_out), .link_up(link_up),
    .match_ok(match_ok), .match_fail(match_fail), .retry_cnt(retry_cnt),
    .link_state(link_state)
  );

  always #5 clk_100 = ~clk_100;

  typedef struct {
    int ph;       // current phase
    int elapsed;  // advertise cycles used in the current attempt
    int bo;       // backoff cycles spent
    int retries;  // timed-out attempts
    int run;      // consecutive matching peer samples in this phase
    bit s1, s2;   // peer delay line (two samples)
  } model_t;

  model_t m;
  logic [8:0] sb[$];
  int compared = 0;
  int mismatched = 0;
  int scen_cyc, ok_cnt, ok_at, fail_cnt, fail_at;

  function automatic model_t mreset();
    model_t r;
    r.ph = P_IDLE; r.elapsed = 0; r.bo = 0; r.retries = 0; r.run = 0;
    r.s1 = 1'b0; r.s2 = 1'b0;
    return r;
  endfunction

  // One clock of the handshake rules, applied to the model.
  function automatic model_t mstep(model_t c, bit req, bit can, bit peer);
    model_t n = c;
    bit ps = c.s2;
    n.s2 = c.s1;
    n.s1 = peer;
    if (c.ph == P_IDLE) begin
      if (req && !can) begin
        n.ph = P_ADV; n.elapsed = 0; n.retries = 0;
      end
    end else if (can) begin
      n.ph = P_IDLE;
    end else begin
      case (c.ph)
        P_ADV: begin
          n.elapsed = c.elapsed + 1;
          n.run = ps ? c.run + 1 : 0;
          if (n.run >= H) n.ph = P_CONF;
          else if (n.elapsed == T) begin
            if (c.retries == MAXR - 1) n.ph = P_FAIL;
            else begin
              n.retries = c.retries + 1; n.ph = P_BO; n.bo = 0;
            end
          end
        end
        P_BO: begin
          n.bo = c.bo + 1;
          if (n.bo == 2 * H) begin
            n.ph = P_ADV; n.elapsed = 0;
          end
        end
        P_CONF: begin
          if (!ps) n.ph = P_ADV;
          else begin
            n.run = c.run + 1;
            if (n.run >= H) n.ph = P_LINK;
          end
        end
        P_LINK: begin
          n.run = !ps ? c.run + 1 : 0;
          if (n.run >= H) n.ph = P_FAIL;
        end
        default: n.ph = P_IDLE;
      endcase
    end
    if (n.ph != c.ph) n.run = 0;
    return n;
  endfunction

  function automatic logic [8:0] mexp(model_t n, int old_ph);
    logic r, lu, ok, fl;
    r  = (n.ph == P_ADV) || (n.ph == P_CONF) || (n.ph == P_LINK);
    lu = (n.ph == P_LINK);
    ok = (n.ph == P_LINK) && (old_ph != P_LINK);
    fl = (n.ph == P_FAIL);
    return {r, lu, ok, fl, 2'(n.retries), 3'(n.ph)};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic scen_start();
    scen_cyc = 0; ok_cnt = 0; ok_at = -1; fail_cnt = 0; fail_at = -1;
  endtask

  // Drive one cycle of inputs, push the model's expected outputs.
  task automatic cyc(input bit r, input bit c, input bit p);
    int old;
    logic [8:0] e;
    @(negedge clk_100);
    req_match = r; cancel = c; peer_rdy_in = p;
    old = m.ph;
    m = mstep(m, r, c, p);
    e = mexp(m, old);
    @(posedge clk_100);
    #1;
    sb.push_back(e);
    if (match_ok) begin ok_cnt++; ok_at = scen_cyc + 1; end
    if (match_fail) begin fail_cnt++; fail_at = scen_cyc + 1; end
    scen_cyc++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0);
  endtask

  // Advance with a fixed peer level until the model reaches a phase.
  task automatic run_until(input int target, input bit p, input string name);
    int k = 0;
    while (m.ph != target && k < 400) begin
      cyc(0, 0, p);
      k++;
    end
    if (m.ph != target) chk(name, m.ph, target);
  endtask

  // Scoreboard monitor: compares DUT outputs against queued expectations.
  initial begin
    logic [8:0] e, a;
    int n = 0;
    forever begin
      @(negedge clk_100);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = {rdy_out, link_up, match_ok, match_fail, retry_cnt, link_state};
        compared++;
        n++;
        if (a !== e) begin
          mismatched++;
          $display("FAIL sb#%0d {rdy,link,ok,fail,retry,state}: got %b expected %b", n, a, e);
        end
      end
    end
  end

  initial begin
    int left;
    bit p;
    model_t pk;
    m = mreset();

    // Reset state
    repeat (3) @(negedge clk_100);
    chk("reset_outputs", int'({rdy_out, link_up, match_ok, match_fail, retry_cnt, link_state}), 0);
    @(posedge clk_100); #2; rst = 1'b1;
    idle_cycles(3);
    $display("reset released, outputs idle");

    // Peer always ready
    scen_start();
    cyc(1, 0, 1);
    for (int i = 0; i < 29; i++) cyc(0, 0, 1);
    chk("ready_ok_count", ok_cnt, 1);
    chk("ready_ok_by_12", int'(ok_at >= 1 && ok_at <= 12), 1);
    chk("ready_link_up", int'(link_up), 1);
    chk("ready_retry", int'(retry_cnt), 0);
    $display("peer ready: match_ok at cycle %0d", ok_at);
    cyc(0, 1, 1);
    idle_cycles(4);

    // Peer never ready
    scen_start();
    cyc(1, 0, 0);
    for (int i = 0; i < 329; i++) cyc(0, 0, 0);
    chk("never_fail_count", fail_cnt, 1);
    chk("never_fail_window", int'(fail_at >= 315 && fail_at <= 320), 1);
    chk("never_retry", int'(retry_cnt), 2);
    chk("never_state", int'(link_state), 0);
    $display("peer never ready: match_fail at cycle %0d", fail_at);

    // Glitch before confirmation
    scen_start();
    cyc(1, 0, 1);
    cyc(0, 0, 1); cyc(0, 0, 1); cyc(0, 0, 0);
    for (int i = 0; i < 30; i++) cyc(0, 0, 1);
    chk("glitch_adv_ok", ok_cnt, 1);
    $display("glitch in advertise: match_ok at cycle %0d", ok_at);
    cyc(0, 1, 1);
    idle_cycles(4);

    // Glitch during CONFIRM
    scen_start();
    cyc(1, 0, 1);
    run_until(P_CONF, 1, "reach_confirm");
    cyc(0, 0, 0);
    for (int i = 0; i < 30; i++) cyc(0, 0, 1);
    chk("glitch_conf_ok", ok_cnt, 1);
    chk("glitch_conf_linked", int'(link_up), 1);
    $display("glitch in confirm: match_ok at cycle %0d", ok_at);

    // Link loss: short drop tolerated, long drop fails
    scen_start();
    for (int i = 0; i < 3; i++) cyc(0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1);
    chk("short_drop_link", int'(link_up), 1);
    chk("short_drop_nofail", fail_cnt, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0);
    chk("long_drop_fail", fail_cnt, 1);
    chk("long_drop_link", int'(link_up), 0);
    $display("link loss: match_fail at cycle %0d", fail_at);
    idle_cycles(4);

    // Cancel during ADVERTISE, BACKOFF, LINKED
    scen_start();
    cyc(1, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0);
    cyc(0, 1, 0);
    chk("cancel_adv_rdy", int'(rdy_out), 0);
    cyc(1, 0, 0);
    run_until(P_BO, 0, "reach_backoff");
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    chk("cancel_bo_state", int'(link_state), 0);
    cyc(1, 0, 1);
    run_until(P_LINK, 1, "reach_linked");
    cyc(0, 0, 1);
    cyc(0, 1, 1);
    chk("cancel_link_up", int'(link_up), 0);
    chk("cancel_nofail", fail_cnt, 0);
    $display("cancels: fail pulses %0d", fail_cnt);
    idle_cycles(4);

    // Cancel on the qualifying cycle
    scen_start();
    cyc(1, 0, 1);
    for (int i = 0; i < 40; i++) begin
      pk = mstep(m, 0, 0, 1);
      if (pk.ph == P_LINK) begin
        cyc(0, 1, 1);
        break;
      end
      cyc(0, 0, 1);
    end
    idle_cycles(3);
    chk("cancel_qual_no_ok", ok_cnt, 0);
    chk("cancel_qual_idle", int'(link_state), 0);
    $display("cancel at qualification: ok pulses %0d", ok_cnt);

    // Asynchronous reset mid-CONFIRM
    cyc(1, 0, 1);
    run_until(P_CONF, 1, "reach_confirm2");
    cyc(0, 0, 1);
    @(negedge clk_100); #2;
    rst = 1'b0;
    #1;
    chk("async_reset_outputs",
        int'({rdy_out, link_up, match_ok, match_fail, retry_cnt, link_state}), 0);
    m = mreset();
    @(posedge clk_100); #2; rst = 1'b1;
    scen_start();
    cyc(1, 0, 1);
    for (int i = 0; i < 19; i++) cyc(0, 0, 1);
    chk("after_reset_ok", ok_cnt, 1);
    chk("after_reset_retry", int'(retry_cnt), 0);
    $display("async reset: restart ok pulses %0d", ok_cnt);
    cyc(0, 1, 0);
    idle_cycles(3);

    // Random traffic
    left = 0;
    p = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if (left == 0) begin
        p = ($urandom_range(0, 3) != 0);
        left = $urandom_range(1, 16);
      end
      left--;
      cyc((m.ph == P_IDLE) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 49) == 0),
          ($urandom_range(0, 149) == 0), p);
    end
    $display("random traffic: 2500 cycles");

    // Drain the scoreboard
    for (int k = 0; k < 5 && sb.size() > 0; k++) @(posedge clk_100);
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
